seq_multiplier: RTL and testbench

//   Parametrised sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/seq_multiplier.sv | 144 ++++++++++++++
 tb/tb_seq_multiplier.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product in WIDTH cycles.
// One adder is reused every cycle; a start/done handshake brackets each job.
// Optional feature macro: SIGNED_MODE_EN adds the signed_mode port (two's complement
// operands handled as magnitudes, product negated when the operand signs differ).
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef SIGNED_MODE_EN
    input  logic               signed_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = 2 * WIDTH + 1;
    localparam int unsigned HW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, next_state;
    logic [AW-1:0]   acc, acc_d;
    logic [WIDTH-1:0] mcand, mcand_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            busy_d, done_d;
    logic [PW-1:0]   product_d;

    // Per-cycle datapath: upper half plus optional multiplicand, then shift right
    logic [HW-1:0]   sum;
    logic [HW-1:0]   upper_next;
    logic [AW-1:0]   step;
    logic [PW-1:0]   result;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SIGNED_MODE_EN
    logic            neg, neg_d;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
`ifdef SIGNED_MODE_EN
            neg     <= 1'b0;
`endif
        end else begin
            acc     <= acc_d;
            mcand   <= mcand_d;
            cnt     <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            product <= product_d;
`ifdef SIGNED_MODE_EN
            neg     <= neg_d;
`endif
        end
    end

    // Next-state, datapath step and registered-output next values
    always_comb begin
        next_state = state;
        acc_d      = acc;
        mcand_d    = mcand;
        cnt_d      = cnt;
        busy_d     = busy;
        done_d     = 1'b0;
        product_d  = product;
        a_mag      = A;
        b_mag      = B;
`ifdef SIGNED_MODE_EN
        neg_d      = neg;
        if (signed_mode && A[WIDTH-1]) begin
            a_mag = WIDTH'(~A + WIDTH'(1));
        end
        if (signed_mode && B[WIDTH-1]) begin
            b_mag = WIDTH'(~B + WIDTH'(1));
        end
`endif

        // acc[AW-1] is always zero after a shift, so the add cannot lose a carry
        sum        = acc[AW-1:WIDTH] + HW'(mcand);
        upper_next = acc[0] ? sum : acc[AW-1:WIDTH];
        step       = {1'b0, upper_next, acc[WIDTH-1:1]};
        result     = step[PW-1:0];
`ifdef SIGNED_MODE_EN
        if (neg) begin
            result = PW'(~step[PW-1:0] + PW'(1));
        end
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    mcand_d    = a_mag;
                    acc_d      = {HW'(0), b_mag};
                    cnt_d      = CW'(WIDTH);
                    busy_d     = 1'b1;
                    next_state = RUN;
`ifdef SIGNED_MODE_EN
                    neg_d      = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
`endif
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    product_d  = result;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=4.
// Define SIGNED_MODE_EN for both files to exercise the signed-mode vectors.
module tb_seq_multiplier;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic [2*WIDTH-1:0] product;

    int checks;
    int errors;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
`ifdef SIGNED_MODE_EN
        .signed_mode (signed_mode),
`endif
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one start request; returns #1 after the edge that samples it
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
        start = 1'b1;
        A = a;
        B = b;
        signed_mode = sm;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done; returns number of edges waited
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Count done pulses over a number of cycles
    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
    endtask

    // Full job: launch, check latency, product and single-cycle done
    task automatic run_job(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic sm, input logic [7:0] exp);
        int n;
        launch(a, b, sm);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'd4);
        check({tag, "_product"}, 32'(product), 32'(exp));
        @(posedge clk);
        #1;
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int n;
        int pulses;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        signed_mode = 1'b0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 10 x 3
        run_job("t2", 4'b1010, 4'b0011, 1'b0, 8'h1E);

        // Asynchronous reset mid-cycle clears outputs immediately
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_product", 32'(product), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 15 x 15 then back-to-back start in the done cycle
        launch(4'hF, 4'hF, 1'b0);
        wait_done(n);
        check("t3_latency", 32'(n), 32'd4);
        check("t3_product", 32'(product), 32'hE1);
        check("t3_done_cycle_idle", 32'(busy), 32'd0);
        launch(4'h0, 4'h9, 1'b0);
        check("t3b_accepted", 32'(busy), 32'd1);
        check("t3b_product_held", 32'(product), 32'hE1);
        wait_done(n);
        check("t3b_latency", 32'(n), 32'd4);
        check("t3b_product", 32'(product), 32'h00);
        @(posedge clk);
        #1;

        // Start while busy is ignored
        launch(4'd5, 4'd6, 1'b0);
        start = 1'b1;
        A = 4'd15;
        B = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("t4_latency", 32'(n), 32'd3);
        check("t4_product", 32'(product), 32'h1E);
        count_done(10, pulses);
        check("t4_single_done", 32'(pulses), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);

        // Reset mid-RUN abandons the job
        launch(4'd7, 4'd7, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_product", 32'(product), 32'd0);
        count_done(6, pulses);
        check("t5_no_done", 32'(pulses), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_job("t5b", 4'd2, 4'd3, 1'b0, 8'h06);

`ifdef SIGNED_MODE_EN
        run_job("t6_neg", 4'b1000, 4'b0111, 1'b1, 8'hC8);
        run_job("t6_minmin", 4'b1000, 4'b1000, 1'b1, 8'h40);
        run_job("t6_unsigned", 4'b1000, 4'b0111, 1'b0, 8'h38);
        run_job("t6_negneg", 4'b1111, 4'b1101, 1'b1, 8'h03);
`else
        run_job("t6_unsigned", 4'b1000, 4'b0111, 1'b0, 8'h38);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
